// File: rtl/scpu_pkg.sv
// Shared sCPU datapath constants and the demux slot state encoding.
package scpu_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_1to2_4bits_if.sv
// Valid/ready bundle of the 1-to-2 demux: one input stream, two output streams.
// Transfer counters are present only when DEMUX_STATS_EN is defined.
interface demux_1to2_4bits_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
`ifdef DEMUX_STATS_EN
  logic [7:0]       out0_count;
  logic [7:0]       out1_count;
`endif

  // Producer and both consumers sit on the master side.
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX_STATS_EN
    , input out0_count, out1_count
`endif
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX_STATS_EN
    , output out0_count, out1_count
`endif
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding slot of the demux: data register, EMPTY/FULL flag and,
// with DEMUX_STATS_EN, a saturating count of completed drains.
module demux_slot
  import scpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  slot_state_e      state_p0;
  slot_state_e      state_nxt;
  logic [WIDTH-1:0] data_p0;
  logic             drain;

  assign valid = (state_p0 == SLOT_FULL);
  assign data  = data_p0;
  assign drain = valid & ready;

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (drain && !load) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  // Stage p0: slot state and held data
  always_ff @(posedge clk) begin
    if (rst) state_p0 <= SLOT_EMPTY;
    else     state_p0 <= state_nxt;
  end

  // Loading only on accept keeps data stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst)       data_p0 <= '0;
    else if (load) data_p0 <= load_data;
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] count_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)        count_p0 <= '0;
    else if (drain) count_p0 <= sat_inc(count_p0);
  end

  assign count = count_p0;
`endif

endmodule

// File: rtl/demux_1to2_4bits.sv
// Registered 1-to-2 valid/ready demultiplexer; in_sel steers to out0 or out1.
// Optional per-output transfer counters with DEMUX_STATS_EN.
module demux_1to2_4bits
  import scpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic               clk,
  input logic               rst,
  demux_1to2_4bits_if.slave bus
);

  logic acc;
  logic load0;
  logic load1;

  // Readiness looks only at the selected slot, so a stalled consumer never
  // blocks traffic headed to the other one.
  always_comb begin
    bus.in_ready = bus.in_sel ? (~bus.out1_valid | bus.out1_ready)
                              : (~bus.out0_valid | bus.out0_ready);
  end

  assign acc   = bus.in_valid & bus.in_ready;
  assign load0 = acc & ~bus.in_sel;
  assign load1 = acc &  bus.in_sel;

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (bus.in_data),
    .ready     (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data)
`ifdef DEMUX_STATS_EN
    ,
    .count     (bus.out0_count)
`endif
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (bus.in_data),
    .ready     (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .count     (bus.out1_count)
`endif
  );

endmodule

// File: tb/tb_demux_1to2_4bits.sv
// Directed table-driven bench for demux_1to2_4bits; count checks only when
// DEMUX_STATS_EN is defined.
module tb_demux_1to2_4bits;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  demux_1to2_4bits_if #(.WIDTH(4)) bus ();

  demux_1to2_4bits dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [3:0] d;
    logic       sel;
    logic       vld;
    logic       r0;
    logic       r1;
    logic       e_ir;
    logic       e_v0;
    logic [3:0] e_d0;
    logic       e_v1;
    logic [3:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t vec [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] d, input logic sel, input logic vld,
                       input logic r0, input logic r1);
    bus.in_data    = d;
    bus.in_sel     = sel;
    bus.in_valid   = vld;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name, input logic [7:0] c0, input logic [7:0] c1);
`ifdef DEMUX_STATS_EN
    check({name, "_c0"}, {24'd0, bus.out0_count}, {24'd0, c0});
    check({name, "_c1"}, {24'd0, bus.out1_count}, {24'd0, c1});
`else
    if (c0 === 8'hxx && c1 === 8'hxx) $display("unreachable %s", name);
`endif
  endtask

  initial begin
    //        d     sel   vld   r0    r1    ir    v0    d0    v1    d1    c0     c1
    vec[0]  = {4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd0};
    vec[1]  = {4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 8'd0, 8'd0};
    vec[2]  = {4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 4'h5, 8'd1, 8'd0};
    vec[3]  = {4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 4'h5, 8'd1, 8'd1};
    vec[4]  = {4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 4'h5, 8'd1, 8'd1};
    vec[5]  = {4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 4'h5, 8'd1, 8'd1};
    vec[6]  = {4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 4'h5, 8'd1, 8'd1};
    vec[7]  = {4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 4'h9, 8'd1, 8'd1};
    vec[8]  = {4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 4'h9, 8'd1, 8'd1};
    vec[9]  = {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'h9, 8'd1, 8'd1};
    vec[10] = {4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'h9, 8'd2, 8'd1};
    vec[11] = {4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h9, 8'd2, 8'd2};
    vec[12] = {4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h9, 8'd3, 8'd2};

    // Reset then idle
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ir", {31'd0, bus.in_ready}, 32'd1);
    check("rst_v0", {31'd0, bus.out0_valid}, 32'd0);
    check("rst_v1", {31'd0, bus.out1_valid}, 32'd0);
    check("rst_d0", {28'd0, bus.out0_data}, 32'd0);
    check("rst_d1", {28'd0, bus.out1_data}, 32'd0);
    check_counts("rst", 8'd0, 8'd0);
    next_cycle();

    // Routing, backpressure, independent slots, simultaneous drain+load
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].d, vec[i].sel, vec[i].vld, vec[i].r0, vec[i].r1);
      @(negedge clk);
      check($sformatf("v%0d_ir", i), {31'd0, bus.in_ready}, {31'd0, vec[i].e_ir});
      check($sformatf("v%0d_v0", i), {31'd0, bus.out0_valid}, {31'd0, vec[i].e_v0});
      check($sformatf("v%0d_d0", i), {28'd0, bus.out0_data}, {28'd0, vec[i].e_d0});
      check($sformatf("v%0d_v1", i), {31'd0, bus.out1_valid}, {31'd0, vec[i].e_v1});
      check($sformatf("v%0d_d1", i), {28'd0, bus.out1_data}, {28'd0, vec[i].e_d1});
      check_counts($sformatf("v%0d", i), vec[i].e_c0, vec[i].e_c1);
      next_cycle();
    end

    // Sustained one word per cycle into draining slot 0 (still holding 4'h2)
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("str%0d_ir", i), {31'd0, bus.in_ready}, 32'd1);
      check($sformatf("str%0d_v0", i), {31'd0, bus.out0_valid}, 32'd1);
      check($sformatf("str%0d_d0", i), {28'd0, bus.out0_data}, (i == 0) ? 32'd2 : 32'(i - 1));
      next_cycle();
    end
    drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("str_last_v0", {31'd0, bus.out0_valid}, 32'd1);
    check("str_last_d0", {28'd0, bus.out0_data}, 32'd9);
    check_counts("str", 8'd13, 8'd2);
    next_cycle();
    @(negedge clk);
    check("str_empty_v0", {31'd0, bus.out0_valid}, 32'd0);
    check_counts("str_end", 8'd14, 8'd2);

    // Reset while both slots are full
    next_cycle();
    drive(4'h4, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_v0", {31'd0, bus.out0_valid}, 32'd1);
    check("full_d1", {28'd0, bus.out1_data}, 32'd6);
    check("full_ir", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_v0", {31'd0, bus.out0_valid}, 32'd0);
    check("mid_rst_v1", {31'd0, bus.out1_valid}, 32'd0);
    check("mid_rst_ir", {31'd0, bus.in_ready}, 32'd1);
    check_counts("mid_rst", 8'd0, 8'd0);
    next_cycle();

`ifdef DEMUX_STATS_EN
    // Counter saturation: 300 drains on out1
    for (int i = 0; i < 300; i++) begin
      drive(4'(i), 1'b1, 1'b1, 1'b0, 1'b1);
      next_cycle();
    end
    drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    check_counts("sat", 8'd0, 8'd255);
    drive(4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
    next_cycle();
    drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    check_counts("sat_hold", 8'd0, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
